// File: rtl/packet_rx_pkg.sv
// Shared Structures package: the UART packet stream record and the default frame sync byte.
package Structures;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

  typedef struct packed {
    logic [7:0] Destination;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       Valid;
    logic       SoP;
    logic       EoP;
  } UART_PACKET;

  localparam UART_PACKET UART_PACKET_IDLE = '{
    Destination: 8'h00, Source: 8'h00, Length: 8'h00, Data: 8'h00,
    Valid: 1'b0, SoP: 1'b0, EoP: 1'b0
  };

endpackage

// File: rtl/packet_rx.sv
// Byte-stream framer: SYNC, Destination, Source, Length, then Length payload beats on opRxPacket.
// Optional inter-byte timeout compiled in with macro PACKET_RX_TIMEOUT_EN.
module packet_rx
  import Structures::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output UART_PACKET opRxPacket,
  output logic       opFrameError
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEST = 3'd1,
    SRC  = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4
  } state_e;

  state_e     state_q, state_d;
  UART_PACKET pkt_q, pkt_d;
  logic [7:0] rem_q, rem_d;
  logic       timeout_s;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("packet_rx: TIMEOUT_CYCLES must be nonzero");
  end

`ifdef PACKET_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q;

  // Idle clocks since the last accepted byte; only meaningful inside a frame.
  assign timeout_s = (state_q != IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

  // Timeout counter next value
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (ipRxValid || (state_q == IDLE) || timeout_s) begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end else begin
      tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // Timeout counter and abort pulse registers
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= timeout_s;
    end
  end

  assign opFrameError = err_q;
`else
  assign timeout_s    = 1'b0;
  assign opFrameError = 1'b0;
`endif

  // State, payload counter and packet registers
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      pkt_q   <= UART_PACKET_IDLE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pkt_q   <= pkt_d;
    end
  end

  // Next-state logic; a timeout abort overrides any byte arriving in the same cycle
  always_comb begin
    state_d = state_q;
    if (timeout_s) begin
      state_d = IDLE;
    end else if (ipRxValid) begin
      case (state_q)
        IDLE:    state_d = (ipRxData == SYNC_BYTE) ? DEST : IDLE;
        DEST:    state_d = SRC;
        SRC:     state_d = LEN;
        LEN:     state_d = (ipRxData == 8'd0) ? IDLE : DATA;
        DATA:    state_d = (rem_q == 8'd1) ? IDLE : DATA;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Packet field updates; header fields hold until the next header overwrites them
  always_comb begin
    pkt_d       = pkt_q;
    pkt_d.Valid = 1'b0;
    pkt_d.SoP   = 1'b0;
    pkt_d.EoP   = 1'b0;
    rem_d       = rem_q;
    if (ipRxValid && !timeout_s) begin
      case (state_q)
        IDLE: rem_d = rem_q;
        DEST: pkt_d.Destination = ipRxData;
        SRC:  pkt_d.Source = ipRxData;
        LEN: begin
          pkt_d.Length = ipRxData;
          rem_d        = ipRxData;
        end
        DATA: begin
          pkt_d.Data  = ipRxData;
          pkt_d.Valid = 1'b1;
          pkt_d.SoP   = (rem_q == pkt_q.Length);
          pkt_d.EoP   = (rem_q == 8'd1);
          rem_d       = rem_q - 8'd1;
        end
        default: rem_d = rem_q;
      endcase
    end else begin
      rem_d = rem_q;
    end
  end

  assign opRxPacket = pkt_q;

endmodule
